// File: rtl/wb_master_pkg.sv
// Shared definitions for the SDRAM Wishbone burst master:
// FSM encoding, byte-select constant and default ack timeout.
package wb_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CYC  = 2'd1,
        STB  = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [3:0]  SEL_ALL         = 4'hF;
    localparam int unsigned DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/sdram_wb_master.sv
// Burst master: turns a user read/write burst request into one Wishbone
// cycle per word toward the SDRAM, with a per-word ack timeout.
module sdram_wb_master
    import wb_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [7:0]  req_len,
    input  logic [31:0] wr_data,
    output logic        wr_ready,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        err,
    output logic        cyc_i,
    output logic        stb_i,
    output logic        we_i,
    output logic [3:0]  sel_i,
    output logic [31:0] addr_i,
    output logic [31:0] data_i,
    input  logic [31:0] data_o,
    input  logic        stall_o,
    input  logic        sdram_ack
);

    localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          we_q;
    logic [7:0]    rem_q;
    logic [TW-1:0] tmo_q;

    logic accept, enter_cyc, acked, finish, abort, cap_wr, stb_wait;

    // Both a stalled strobe and a missing ack consume the timeout budget.
    assign stb_wait = stall_o | ~sdram_ack;
    // On the first word the direction is still on the request port, not latched.
    assign cap_wr   = enter_cyc & ((state_q == IDLE) ? req_we : we_q);
    assign sel_i    = SEL_ALL;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        enter_cyc = 1'b0;
        acked     = 1'b0;
        finish    = 1'b0;
        abort     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (req_len == 8'd0) begin
                        finish = 1'b1;
                    end else begin
                        state_d   = CYC;
                        enter_cyc = 1'b1;
                    end
                end
            end
            CYC: state_d = STB;
            STB: begin
                // Ack wins over a timeout expiring in the same cycle.
                if (sdram_ack) begin
                    acked   = 1'b1;
                    state_d = GAP;
                end else if (tmo_q == TMO_LAST) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (rem_q != 8'd0) begin
                    state_d   = CYC;
                    enter_cyc = 1'b1;
                end else begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        cyc_i     = (state_q == CYC) || (state_q == STB);
        stb_i     = (state_q == STB);
        we_i      = cyc_i & we_q;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            rem_q    <= '0;
            tmo_q    <= '0;
            addr_i   <= '0;
            data_i   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            wr_ready <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done     <= finish | abort;
            err      <= abort;
            rd_valid <= acked & ~we_q;
            wr_ready <= cap_wr;

            if (state_q == STB) begin
                if (stb_wait) tmo_q <= tmo_q + TW'(1);
            end else begin
                tmo_q <= '0;
            end

            if (accept) begin
                we_q   <= req_we;
                rem_q  <= req_len;
                addr_i <= req_addr;
            end else if (enter_cyc) begin
                addr_i <= addr_i + 32'd1;
            end

            if (cap_wr) data_i <= wr_data;

            if (acked) begin
                rem_q <= rem_q - 8'd1;
                if (!we_q) rd_data <= data_o;
            end
        end
    end

endmodule

// File: tb/tb_sdram_wb_master.sv
// Randomized bench for sdram_wb_master against a transaction-level model
// with a simple SDRAM responder holding word memory in an associative array.
module tb_sdram_wb_master;

    localparam int unsigned TMO = 8;

    logic        CLK = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [7:0]  req_len = '0;
    logic [31:0] wr_data = '0;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic        err;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o = '0;
    logic        stall_o = 1'b0;
    logic        sdram_ack = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    logic [31:0] mem [logic [31:0]];

    always #5 CLK = ~CLK;

    sdram_wb_master #(.TIMEOUT(TMO)) dut (
        .CLK(CLK), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len),
        .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .done(done), .err(err),
        .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .sel_i(sel_i),
        .addr_i(addr_i), .data_i(data_i),
        .data_o(data_o), .stall_o(stall_o), .sdram_ack(sdram_ack)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // One burst: model predicts addresses, data and done timing; responder acks
    // in the (delay+1)-th strobe cycle of each word, or never when no_ack is set.
    task automatic run_txn(input logic we, input logic [31:0] addr, input int unsigned len,
                           input int unsigned delay, input bit no_ack, input logic [31:0] wbase);
        logic [31:0] exp_addr[$];
        logic [31:0] exp_rd[$];
        logic [31:0] wdata[$];
        logic [31:0] got_addr[$];
        logic [31:0] got_rd[$];
        logic [31:0] a;
        int unsigned n_issue, n_done, exp_done_cyc;
        int unsigned wr_cnt = 0, stb_run = 0, cyc_pulses = 0;
        bit prev_stb = 0, prev_cyc = 0, prev_ack = 0, seen_done = 0;

        n_issue = (len == 0) ? 0 : (no_ack ? 1 : len);
        n_done  = no_ack ? 0 : len;
        exp_done_cyc = (len == 0) ? 1 : (no_ack ? TMO + 2 : len * (delay + 3) + 1);
        for (int i = 0; i < int'(len); i++) begin
            a = addr + 32'(i);
            exp_addr.push_back(a);
            wdata.push_back(wbase + 32'(i));
            if (!we) begin
                if (!mem.exists(a)) mem[a] = $urandom;
                exp_rd.push_back(mem[a]);
            end
        end

        @(negedge CLK);
        check_eq("ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_len   = 8'(len);
        wr_data   = (wdata.size() > 0) ? wdata[0] : $urandom;
        @(negedge CLK);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_len   = 8'($urandom);
        req_we    = ~we;

        for (int c = 1; c <= 2000 && !seen_done; c++) begin
            if (c > 1) @(negedge CLK);
            if (cyc_i && !prev_cyc) cyc_pulses++;
            if (stb_i && !prev_stb) begin
                got_addr.push_back(addr_i);
                check_eq("cyc_before_stb", {30'd0, prev_cyc, prev_stb}, 32'd2);
                check_eq("we_i", we_i, we);
                check_eq("sel_i", sel_i, 4'hF);
            end
            if (!stb_i && prev_stb) check_eq("stb_len", stb_run, no_ack ? TMO : delay + 1);
            stb_run = stb_i ? stb_run + 1 : 0;
            if (rd_valid) begin
                got_rd.push_back(rd_data);
                check_eq("rd_valid_after_ack", prev_ack, 1);
            end
            if (wr_ready) begin
                wr_cnt++;
                if (wr_cnt < wdata.size()) wr_data = wdata[wr_cnt];
            end
            if (done) begin
                seen_done = 1;
                check_eq("done_cycle", c, exp_done_cyc);
                check_eq("err", err, no_ack);
                check_eq("cyc_at_done", {cyc_i, stb_i, we_i}, 0);
                check_eq("ready_at_done", req_ready, 1);
            end
            if (stb_i && !no_ack && stb_run == delay + 1) begin
                sdram_ack = 1'b1;
                stall_o   = 1'b0;
                data_o    = mem.exists(addr_i) ? mem[addr_i] : 32'd0;
                if (we_i) mem[addr_i] = data_i;
            end else if (stb_i) begin
                sdram_ack = 1'b0;
                stall_o   = 1'($urandom_range(0, 1));
                data_o    = $urandom;
            end else begin
                sdram_ack = ($urandom_range(0, 3) == 0);
                stall_o   = 1'b0;
                data_o    = $urandom;
            end
            prev_ack = sdram_ack && stb_i;
            prev_stb = stb_i;
            prev_cyc = cyc_i;
        end
        if (!seen_done) check_eq("done_wait_expired", 0, 1);

        @(negedge CLK);
        sdram_ack = 1'b0;
        check_eq("done_one_cycle", {done, err}, 0);

        check_eq("cyc_pulses", cyc_pulses, n_issue);
        check_eq("addr_count", got_addr.size(), n_issue);
        for (int i = 0; i < int'(n_issue) && i < got_addr.size(); i++)
            check_eq("addr_i", got_addr[i], exp_addr[i]);
        if (we) begin
            check_eq("wr_ready_count", wr_cnt, n_issue);
            check_eq("rd_valid_count", got_rd.size(), 0);
            for (int i = 0; i < int'(n_done); i++)
                check_eq("mem_word", mem.exists(exp_addr[i]) ? mem[exp_addr[i]] : 32'hXXXX_XXXX, wdata[i]);
        end else begin
            check_eq("wr_ready_count", wr_cnt, 0);
            check_eq("rd_valid_count", got_rd.size(), n_done);
            for (int i = 0; i < int'(n_done) && i < got_rd.size(); i++)
                check_eq("rd_data", got_rd[i], exp_rd[i]);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_bus"}, {cyc_i, stb_i, we_i}, 0);
        check_eq({tag, "_ready"}, req_ready, 1);
        check_eq({tag, "_sel"}, sel_i, 4'hF);
        check_eq({tag, "_addr"}, addr_i, 0);
        check_eq({tag, "_data"}, data_i, 0);
        check_eq({tag, "_rd_data"}, rd_data, 0);
        check_eq({tag, "_pulses"}, {rd_valid, wr_ready, done, err}, 0);
    endtask

    initial begin
        bit hit;
        #1 rst_n = 1'b0;
        #2 check_reset_state("reset");
        @(negedge CLK);
        rst_n = 1'b1;

        run_txn(1'b1, 32'h10, 3, 4, 0, 32'hA);
        mem[32'h20] = 32'h1234_5678;
        mem[32'h21] = 32'hDEAD_BEEF;
        run_txn(1'b0, 32'h20, 2, 1, 0, 32'h0);
        run_txn(1'b0, 32'h80, 0, 0, 0, 32'h0);
        run_txn(1'b1, 32'h90, 0, 0, 0, 32'h0);
        run_txn(1'b0, 32'h30, 2, 0, 1, 32'h0);
        run_txn(1'b1, 32'h34, 3, 0, 1, 32'h55);
        run_txn(1'b0, 32'h60, 2, TMO - 1, 0, 32'h0);
        run_txn(1'b1, 32'hFFFF_FFFF, 2, 0, 0, 32'h7700);

        // Asynchronous reset in the middle of a strobe.
        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40; req_len = 8'd3;
        @(negedge CLK);
        req_valid = 1'b0;
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            if (stb_i) hit = 1;
            else @(negedge CLK);
        end
        check_eq("stb_before_reset", stb_i, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_state("midreset");
        @(negedge CLK);
        rst_n = 1'b1;
        sdram_ack = 1'b0;
        run_txn(1'b0, 32'h50, 1, 2, 0, 32'h0);

        for (int n = 0; n < 25; n++) begin
            logic        r_we;
            logic [31:0] r_addr;
            int unsigned r_len, r_delay;
            bit          r_noack;
            r_we    = 1'($urandom_range(0, 1));
            r_addr  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
            r_len   = $urandom_range(0, 5);
            r_delay = ($urandom_range(0, 4) == 0) ? TMO - 1 : $urandom_range(0, 5);
            r_noack = (r_len > 0) && ($urandom_range(0, 5) == 0);
            run_txn(r_we, r_addr, r_len, r_delay, r_noack, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sdram_wb_master.md
SDRAM_WB_MASTER -- requirements
Module: sdram_wb_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: maximum cycles stb_i stays asserted waiting for sdram_ack before abort.
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  user requests a burst.
REQ-005 SHALL have port req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready.
REQ-006 SHALL have port req_we  input  1  1 = write burst, 0 = read burst.
REQ-007 SHALL have port req_addr  input  32  first word address.
REQ-008 SHALL have port req_len  input  8  word count, 0..255.
REQ-009 SHALL have port wr_data  input  32  next write word, held stable until wr_ready pulse.
REQ-010 SHALL have port wr_ready  output  1  one-cycle pulse when wr_data is captured.
REQ-011 SHALL have port rd_data  output  32  last word read.
REQ-012 SHALL have port rd_valid  output  1  one-cycle pulse, rd_data valid.
REQ-013 SHALL have port done  output  1  one-cycle pulse at burst end (normal or aborted).
REQ-014 SHALL have port err  output  1  one-cycle pulse, coincident with done, on timeout abort.
REQ-015 SHALL have ports cyc_i, stb_i, we_i  output  1 each  Wishbone cycle, strobe, write enable toward SDRAM.
REQ-016 SHALL have ports sel_i  output  4, addr_i  output  32, data_i  output  32  Wishbone byte select, address, write data.
REQ-017 SHALL have ports data_o  input  32, stall_o  input  1, sdram_ack  input  1  Wishbone read data, stall, acknowledge from SDRAM.

Function
REQ-018 SHALL implement FSM states IDLE, CYC, STB, GAP; on accept, latch we, addr, len into registers.
REQ-019 IDLE: req_len == 0 SHALL pulse done on the next cycle and issue no bus cycle; otherwise go to CYC.
REQ-020 CYC: cyc_i = 1, stb_i = 0 for exactly one cycle, then STB; for writes, data_i <= wr_data and wr_ready pulses on CYC entry.
REQ-021 STB: cyc_i = stb_i = 1 with addr_i, we_i, data_i stable; stall_o high SHALL hold the current word and keep counting toward timeout.
REQ-022 STB on sdram_ack: go to GAP; for reads, rd_data <= data_o and rd_valid pulses the following cycle.
REQ-023 GAP: cyc_i = stb_i = 0 for exactly one cycle (responder returns to wait); remaining > 0 -> CYC with addr + 1; else IDLE with done pulse.
REQ-024 Address SHALL advance by 1 per word (word addressing) and wrap 0xFFFF_FFFF -> 0x0000_0000.
REQ-025 sel_i SHALL be constant 4'hF; we_i SHALL follow the latched req_we whenever cyc_i is high and be 0 otherwise.
REQ-026 Timeout: after TIMEOUT consecutive STB cycles without ack, cyc_i/stb_i SHALL drop, done and err SHALL pulse, the remaining words are abandoned, and the FSM returns to IDLE.
REQ-027 sdram_ack outside STB SHALL be ignored; ack arriving in the same cycle the timeout expires SHALL count as success.
REQ-028 req_valid while not in IDLE SHALL be ignored (req_ready = 0).

Reset
REQ-029 rst_n low SHALL immediately force IDLE, cyc_i = stb_i = we_i = 0, addr_i = data_i = rd_data = 0, all pulses 0, req_ready = 1, sel_i = 4'hF, including mid-transfer.

Structure
REQ-030 Shared package wb_master_pkg SHALL hold the FSM state encoding, the SEL_ALL constant, and the default TIMEOUT; the block is a single module with no sub-module.

Verification
REQ-031 Write len 3 at 0x10 with data 0xA, 0xB, 0xC; responder acks 4 cycles after stb -> three separate cyc_i pulses, addr_i 0x10/0x11/0x12, memory holds A/B/C, one done, err 0.
REQ-032 Read len 2 at 0x20 with memory 0x12345678, 0xDEADBEEF -> two rd_valid pulses carrying those values in order, then done.
REQ-033 req_len 0 -> done one cycle after accept; cyc_i never asserts.
REQ-034 TIMEOUT 8, responder never acks -> stb_i high for 8 cycles, then cyc_i/stb_i 0, done and err pulse together, req_ready 1.
REQ-035 rst_n low during STB -> cyc_i/stb_i 0 without waiting for a clock edge; after release, req_ready 1 and a new len-1 read completes.
REQ-036 Write len 2 at 0xFFFFFFFF -> second addr_i is 0x00000000.
